// File: rtl/keypad_entry.sv
// Keypad credential entry: one account digit, a 4-digit PIN, handoff to an
// authenticator, and lockout after repeated rejections. Optional PIN idle abort via KEYPAD_TIMEOUT_EN.
module keypad_entry #(
   parameter int MAX_ATTEMPTS   = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        entry_ready,
   input  logic        auth_valid,
   input  logic        auth_ok,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic        entry_valid,
   output logic [2:0]  digit_count,
   output logic        locked,
   output logic        timeout
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PIN      = 3'd1;
   localparam logic [2:0] S_SEND     = 3'd2;
   localparam logic [2:0] S_WAIT_RES = 3'd3;
   localparam logic [2:0] S_LOCKED   = 3'd4;

   localparam logic [3:0] KEY_CLEAR  = 4'hA;
   localparam logic [3:0] KEY_ENTER  = 4'hB;
   localparam logic [3:0] KEY_CANCEL = 4'hC;

   localparam int            AW      = $clog2(MAX_ATTEMPTS + 1);
   localparam logic [AW-1:0] ATT_MAX = AW'(MAX_ATTEMPTS);

   if (MAX_ATTEMPTS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("keypad_entry: MAX_ATTEMPTS and TIMEOUT_CYCLES must be at least 1");
   end

   logic [2:0]    state;
   logic [AW-1:0] attempts;
   logic [AW-1:0] attempts_inc;
   logic          idle_expire;

   // Saturating increment; the counter never wraps past MAX_ATTEMPTS.
   assign attempts_inc = (attempts == ATT_MAX) ? attempts : attempts + 1'b1;

`ifdef KEYPAD_TIMEOUT_EN
   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive keyless cycle spent in PIN.
   assign idle_expire = (state == S_PIN) && !key_valid && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= idle_expire;
         if (state != S_PIN || key_valid) idle_cnt <= '0;
         else                             idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign idle_expire = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         attempts    <= '0;
         acc_num     <= 4'd0;
         pin         <= 16'd0;
         digit_count <= 3'd0;
         entry_valid <= 1'b0;
         locked      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (key_valid && key_code <= 4'd9) begin
                  acc_num     <= key_code;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
                  state       <= S_PIN;
               end
            end
            S_PIN: begin
               if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (digit_count != 3'd4) begin
                        pin         <= {pin[11:0], key_code};
                        digit_count <= digit_count + 3'd1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     pin         <= 16'd0;
                     digit_count <= 3'd0;
                  end else if (key_code == KEY_ENTER) begin
                     if (digit_count == 3'd4) begin
                        state       <= S_SEND;
                        entry_valid <= 1'b1;
                     end
                  end else if (key_code == KEY_CANCEL) begin
                     state       <= S_IDLE;
                     acc_num     <= 4'd0;
                     pin         <= 16'd0;
                     digit_count <= 3'd0;
                  end
               end else if (idle_expire) begin
                  state       <= S_IDLE;
                  acc_num     <= 4'd0;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
               end
            end
            S_SEND: begin
               if (entry_ready) begin
                  state       <= S_WAIT_RES;
                  entry_valid <= 1'b0;
               end
            end
            S_WAIT_RES: begin
               if (auth_valid) begin
                  if (auth_ok) begin
                     attempts    <= '0;
                     pin         <= 16'd0;
                     digit_count <= 3'd0;
                     state       <= S_IDLE;
                  end else begin
                     attempts <= attempts_inc;
                     if (attempts_inc == ATT_MAX) begin
                        state  <= S_LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state       <= S_PIN;
                        pin         <= 16'd0;
                        digit_count <= 3'd0;
                     end
                  end
               end
            end
            S_LOCKED: begin
               locked <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: entry, clear/cancel, handshake scoreboard,
// rejection lockout, success counter clear, mid-operation reset and idle abort.
module tb_keypad_entry;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        entry_ready;
   logic        auth_valid;
   logic        auth_ok;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic        entry_valid;
   logic [2:0]  digit_count;
   logic        locked;
   logic        timeout;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int sent_cnt = 0;
   logic [15:0] exp_q[$];

   keypad_entry #(.MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .entry_ready(entry_ready), .auth_valid(auth_valid), .auth_ok(auth_ok),
      .acc_num(acc_num), .pin(pin), .entry_valid(entry_valid),
      .digit_count(digit_count), .locked(locked), .timeout(timeout)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted handshake must carry the next expected PIN.
   always @(posedge clk) begin
      if (rst && entry_valid && entry_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) check("hs_unexpected", 32'd1, 32'd0);
         else                   check("hs_pin", {16'd0, pin}, {16'd0, exp_q.pop_front()});
      end
   end

   // Driver tasks
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'hF;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_pin(input logic [15:0] p);
      press(p[15:12]);
      press(p[11:8]);
      press(p[7:4]);
      press(p[3:0]);
   endtask

   task automatic send_ok(input logic [15:0] exp_pin);
      exp_q.push_back(exp_pin);
      sent_cnt++;
      @(negedge clk);
      entry_ready = 1'b1;
      @(negedge clk);
      entry_ready = 1'b0;
      check("ev_drop", {31'd0, entry_valid}, 32'd0);
   endtask

   task automatic auth(input logic ok);
      @(negedge clk);
      auth_valid = 1'b1;
      auth_ok    = ok;
      @(negedge clk);
      auth_valid = 1'b0;
      auth_ok    = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_acc"},  {28'd0, acc_num}, 32'd0);
      check({tag, "_pin"},  {16'd0, pin}, 32'd0);
      check({tag, "_dc"},   {29'd0, digit_count}, 32'd0);
      check({tag, "_ev"},   {31'd0, entry_valid}, 32'd0);
      check({tag, "_lock"}, {31'd0, locked}, 32'd0);
      check({tag, "_to"},   {31'd0, timeout}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      key_valid = 1'b0;
      key_code = 4'hF;
      entry_ready = 1'b0;
      auth_valid = 1'b0;
      auth_ok = 1'b0;
      idle(3);
      check_reset_vals("rst");
      rst = 1'b1;

      // Basic entry 7,1,2,3,4,ENTER then accept
      press(4'hB);
      check("idle_enter_ign", {28'd0, acc_num}, 32'd0);
      press(4'd7);
      check("acc7", {28'd0, acc_num}, 32'd7);
      check("acc7_dc", {29'd0, digit_count}, 32'd0);
      do_pin(16'h1234);
      check("pin1234", {16'd0, pin}, 32'h1234);
      check("dc4", {29'd0, digit_count}, 32'd4);
      press(4'hB);
      check("ev_up", {31'd0, entry_valid}, 32'd1);
      press(4'd9);
      check("send_key_ign", {16'd0, pin}, 32'h1234);
      check("ev_hold", {31'd0, entry_valid}, 32'd1);
      send_ok(16'h1234);
      check("hs_once", hs_cnt, 32'd1);
      auth(1'b1);
      check("ok_pin_clr", {16'd0, pin}, 32'd0);
      check("ok_acc_keep", {28'd0, acc_num}, 32'd7);

      // 5,9,8,ENTER(short),CLEAR,4,3,2,1,6,ENTER
      press(4'd5);
      press(4'd9);
      press(4'd8);
      press(4'hB);
      check("short_enter_ign", {31'd0, entry_valid}, 32'd0);
      check("pin98", {16'd0, pin}, 32'h0098);
      press(4'hA);
      check("clr_pin", {16'd0, pin}, 32'd0);
      check("clr_dc", {29'd0, digit_count}, 32'd0);
      press(4'hE);
      check("code_e_ign", {16'd0, pin}, 32'd0);
      do_pin(16'h4321);
      press(4'd6);
      check("pin4321", {16'd0, pin}, 32'h4321);
      check("dc4_full", {29'd0, digit_count}, 32'd4);
      press(4'hB);
      check("ev_up2", {31'd0, entry_valid}, 32'd1);
      send_ok(16'h4321);
      auth(1'b0);
      check("rej1_pin", {16'd0, pin}, 32'd0);
      check("rej1_acc", {28'd0, acc_num}, 32'd5);
      check("rej1_lock", {31'd0, locked}, 32'd0);

      // Second rejection, then success clears the counter
      do_pin(16'h1111);
      press(4'hB);
      send_ok(16'h1111);
      auth(1'b0);
      check("rej2_lock", {31'd0, locked}, 32'd0);
      do_pin(16'h2222);
      press(4'hB);
      send_ok(16'h2222);
      auth(1'b1);
      press(4'd8);
      do_pin(16'h3333);
      press(4'hB);
      send_ok(16'h3333);
      auth(1'b0);
      do_pin(16'h4444);
      press(4'hB);
      send_ok(16'h4444);
      auth(1'b0);
      check("two_after_ok_nolock", {31'd0, locked}, 32'd0);

      // Third consecutive rejection locks; nothing moves afterwards
      do_pin(16'h5555);
      press(4'hB);
      send_ok(16'h5555);
      auth(1'b0);
      check("lock_set", {31'd0, locked}, 32'd1);
      press(4'd1);
      press(4'hA);
      press(4'hC);
      press(4'hB);
      @(negedge clk);
      entry_ready = 1'b1;
      @(negedge clk);
      entry_ready = 1'b0;
      auth(1'b1);
      check("lock_hold", {31'd0, locked}, 32'd1);
      check("lock_pin", {16'd0, pin}, 32'h5555);
      check("lock_acc", {28'd0, acc_num}, 32'd8);
      check("lock_dc", {29'd0, digit_count}, 32'd4);
      check("lock_ev", {31'd0, entry_valid}, 32'd0);

      // Reset out of lock, then reset while entry_valid is high
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_reset_vals("unlock");
      press(4'd2);
      press(4'd3);
      press(4'hC);
      check("cancel_acc", {28'd0, acc_num}, 32'd0);
      check("cancel_pin", {16'd0, pin}, 32'd0);
      press(4'd4);
      do_pin(16'h9876);
      press(4'hB);
      check("ev_before_rst", {31'd0, entry_valid}, 32'd1);
      #3 rst = 1'b0;
      #1 check_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      press(4'hB);
      check("post_rst_idle", {31'd0, entry_valid}, 32'd0);

      // PIN idle behaviour
      press(4'd3);
      press(4'd1);
`ifdef KEYPAD_TIMEOUT_EN
      idle(9);
      check("to_early", {31'd0, timeout}, 32'd0);
      check("to_early_acc", {28'd0, acc_num}, 32'd3);
      idle(1);
      check("to_pulse", {31'd0, timeout}, 32'd1);
      check("to_acc", {28'd0, acc_num}, 32'd0);
      check("to_pin", {16'd0, pin}, 32'd0);
      idle(1);
      check("to_one_cycle", {31'd0, timeout}, 32'd0);
      press(4'hB);
      check("to_idle", {31'd0, entry_valid}, 32'd0);
`else
      idle(30);
      check("no_to", {31'd0, timeout}, 32'd0);
      check("no_to_acc", {28'd0, acc_num}, 32'd3);
      check("no_to_pin", {16'd0, pin}, 32'h0001);
`endif

      check("hs_count", hs_cnt, sent_cnt);
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
